// File: rtl/skid_buffer.sv
// Two-entry ready/valid pipeline stage with fully registered handshake outputs.
// A skid register absorbs the word in flight when downstream stalls, so input_ready can be a flop.
module skid_buffer #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data
);

  // Bit 0 of the encoding is input_ready and bit 1 is output_valid, so both come straight from flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b01,
    BUSY  = 2'b11,
    FULL  = 2'b10
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] skid_data;
  logic                  insert;
  logic                  remove;

  assign input_ready  = state[0];
  assign output_valid = state[1];
  assign insert       = input_valid & input_ready;
  assign remove       = output_valid & output_ready;

  // output_data only loads on a real insert or flush, so it is stable while stalled.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= EMPTY;
      output_data <= '0;
      skid_data   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (insert) begin
            state       <= BUSY;
            output_data <= input_data;
          end
        end
        BUSY: begin
          if (insert && remove) begin
            output_data <= input_data;
          end else if (insert) begin
            state     <= FULL;
            skid_data <= input_data;
          end else if (remove) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (remove) begin
            state       <= BUSY;
            output_data <= skid_data;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed scenarios plus a queue scoreboard
// that follows every accepted word to the output under random backpressure.
module tb_skid_buffer;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         resetn;
  logic         input_valid;
  logic         input_ready;
  logic [W-1:0] input_data;
  logic         output_valid;
  logic         output_ready;
  logic [W-1:0] output_data;

  int checks = 0;
  int passes = 0;

  logic [W-1:0] sb[$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;

  skid_buffer #(.WORD_WIDTH(W)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard: words are queued at the handshake that accepts them and popped at the one that removes them.
  always @(negedge clock) begin
    if (resetn !== 1'b1) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (output_valid !== 1'b1 || output_data !== stall_data)
          $display("[TB] FAIL stall_stable: got valid=%b data=%h, need valid=1 data=%h",
                   output_valid, output_data, stall_data);
        else
          passes++;
      end
      if (output_valid === 1'b1 && output_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          $display("[TB] FAIL sb_order: got data=%h, need no word (scoreboard empty)", output_data);
        end else begin
          logic [W-1:0] expected;
          expected = sb.pop_front();
          if (output_data !== expected)
            $display("[TB] FAIL sb_order: got data=%h, need %h", output_data, expected);
          else
            passes++;
        end
      end
      if (input_valid === 1'b1 && input_ready === 1'b1)
        sb.push_back(input_data);
      stall_prev = (output_valid === 1'b1 && output_ready === 1'b0);
      stall_data = output_data;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn       = 1'b0;
    input_valid  = 1'b1;
    input_data   = 8'hAA;
    output_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if ({input_ready, output_valid, output_data} !== {1'b1, 1'b0, 8'h00})
        $display("[TB] FAIL reset_hold: got ready=%b valid=%b data=%h, need 1 0 00",
                 input_ready, output_valid, output_data);
      else
        passes++;
    end
    step();
    input_valid = 1'b0;
    resetn      = 1'b1;
    @(negedge clock);
    checks++;
    if ({input_ready, output_valid, output_data} !== {1'b1, 1'b0, 8'h00})
      $display("[TB] FAIL reset_release: got ready=%b valid=%b data=%h, need 1 0 00",
               input_ready, output_valid, output_data);
    else
      passes++;
  endtask

  task automatic test_single_word();
    step();
    input_valid  = 1'b1;
    input_data   = 8'h11;
    output_ready = 1'b0;
    step();
    input_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({input_ready, output_valid, output_data} !== {1'b1, 1'b1, 8'h11})
      $display("[TB] FAIL single_present: got ready=%b valid=%b data=%h, need 1 1 11",
               input_ready, output_valid, output_data);
    else
      passes++;
    step();
    output_ready = 1'b1;
    step();
    output_ready = 1'b0;
    @(negedge clock);
    checks++;
    if ({input_ready, output_valid} !== 2'b10)
      $display("[TB] FAIL single_empty: got ready=%b valid=%b, need 1 0", input_ready, output_valid);
    else
      passes++;
  endtask

  task automatic test_streaming();
    output_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      input_valid = 1'b1;
      input_data  = 8'(i);
      @(negedge clock);
      checks++;
      if (i == 1) begin
        if (output_valid !== 1'b0)
          $display("[TB] FAIL stream_latency: got valid=%b before first edge, need 0", output_valid);
        else
          passes++;
      end else if ({input_ready, output_valid, output_data} !== {1'b1, 1'b1, 8'(i - 1)}) begin
        $display("[TB] FAIL stream_word: got ready=%b valid=%b data=%h, need 1 1 %h",
                 input_ready, output_valid, output_data, 8'(i - 1));
      end else begin
        passes++;
      end
    end
    step();
    input_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({output_valid, output_data} !== {1'b1, 8'h10})
      $display("[TB] FAIL stream_last: got valid=%b data=%h, need 1 10", output_valid, output_data);
    else
      passes++;
    step();
    @(negedge clock);
    checks++;
    if (output_valid !== 1'b0)
      $display("[TB] FAIL stream_drain: got valid=%b, need 0", output_valid);
    else
      passes++;
  endtask

  task automatic test_stall_skid();
    step();
    output_ready = 1'b0;
    input_valid  = 1'b1;
    input_data   = 8'h21;
    step();
    input_data = 8'h22;
    step();
    input_data = 8'h23;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if ({input_ready, output_valid, output_data} !== {1'b0, 1'b1, 8'h21})
        $display("[TB] FAIL skid_full: got ready=%b valid=%b data=%h, need 0 1 21",
                 input_ready, output_valid, output_data);
      else
        passes++;
      step();
    end
    output_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({output_valid, output_data} !== {1'b1, 8'h21})
      $display("[TB] FAIL skid_first: got valid=%b data=%h, need 1 21", output_valid, output_data);
    else
      passes++;
    step();
    @(negedge clock);
    checks++;
    if ({input_ready, output_valid, output_data} !== {1'b1, 1'b1, 8'h22})
      $display("[TB] FAIL skid_second: got ready=%b valid=%b data=%h, need 1 1 22",
               input_ready, output_valid, output_data);
    else
      passes++;
    step();
    input_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({output_valid, output_data} !== {1'b1, 8'h23})
      $display("[TB] FAIL skid_third: got valid=%b data=%h, need 1 23", output_valid, output_data);
    else
      passes++;
    step();
    @(negedge clock);
    checks++;
    if (output_valid !== 1'b0)
      $display("[TB] FAIL skid_empty: got valid=%b, need 0", output_valid);
    else
      passes++;
  endtask

  task automatic test_random_backpressure();
    logic [W-1:0] next_data = 8'h40;
    logic         accepted  = 1'b0;
    logic         drained   = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      step();
      if (accepted) next_data = next_data + 8'd1;
      input_valid  = 1'($urandom_range(0, 1));
      output_ready = 1'($urandom_range(0, 1));
      input_data   = input_valid ? next_data : 'x;
      @(negedge clock);
      accepted = input_valid & input_ready;
    end
    step();
    input_valid  = 1'b0;
    output_ready = 1'b1;
    for (int k = 0; k < 20 && !drained; k++) begin
      @(negedge clock);
      if (output_valid === 1'b0) drained = 1'b1;
      else step();
    end
    checks++;
    if (!drained)
      $display("[TB] FAIL random_drain: got valid=%b after 20 cycles, need 0", output_valid);
    else
      passes++;
    checks++;
    if (sb.size() != 0)
      $display("[TB] FAIL random_lossless: got %0d words left undelivered, need 0", sb.size());
    else
      passes++;
  endtask

  task automatic test_reset_full();
    step();
    output_ready = 1'b0;
    input_valid  = 1'b1;
    input_data   = 8'h31;
    step();
    input_data = 8'h32;
    step();
    input_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({input_ready, output_valid, output_data} !== {1'b0, 1'b1, 8'h31})
      $display("[TB] FAIL rstfull_setup: got ready=%b valid=%b data=%h, need 0 1 31",
               input_ready, output_valid, output_data);
    else
      passes++;
    step();
    resetn       = 1'b0;
    output_ready = 1'b1;
    step();
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if ({input_ready, output_valid, output_data} !== {1'b1, 1'b0, 8'h00})
      $display("[TB] FAIL rstfull_state: got ready=%b valid=%b data=%h, need 1 0 00",
               input_ready, output_valid, output_data);
    else
      passes++;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clock);
      checks++;
      if (output_valid !== 1'b0)
        $display("[TB] FAIL rstfull_discard: got valid=%b data=%h, need valid=0",
                 output_valid, output_data);
      else
        passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_stall_skid();
    test_random_backpressure();
    test_reset_full();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
